// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM for a shared single-ALU / single-memory
// MIPS datapath (add, sub, ori, lw, sw, beq, lui, jal, jr, nop). It sequences
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and mux selects, and counts
// retired instructions.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        im_ready,
  input  logic        dm_ready,
  output logic        PC_en,
  output logic        IR_en,
  output logic        W_en,
  output logic        DM_we,
  output logic [2:0]  ALUop,
  output logic        ALUsrc,
  output logic [1:0]  Wreg_sel,
  output logic [1:0]  Wdata_sel,
  output logic [1:0]  EXT_sel,
  output logic        Shift_sel,
  output logic [1:0]  NPC_sel,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // add and sub share the RTYPE sequence but need different ALU operations,
  // so they are kept as two classes.
  typedef enum logic [3:0] {
    C_NOP, C_ADD, C_SUB, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JR
  } class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t      state_q, state_d;
  class_t      cls_q, dec_class, sel_class;
  logic [31:0] retired_q;
  logic        done;

  // Instruction class decode from the IR fields; anything unrecognised is a NOP.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    dec_class = C_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec_class = C_ADD;
          FN_SUB:  dec_class = C_SUB;
          FN_JR:   dec_class = C_JR;
          default: dec_class = C_NOP;
        endcase
      end
      OP_ORI:  dec_class = C_ORI;
      OP_LUI:  dec_class = C_LUI;
      OP_LW:   dec_class = C_LW;
      OP_SW:   dec_class = C_SW;
      OP_BEQ:  dec_class = C_BEQ;
      OP_JAL:  dec_class = C_JAL;
      default: dec_class = C_NOP;
    endcase
  end

  // Next-state logic; done flags the final edge of an instruction.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (im_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (dec_class)
          C_NOP:   begin state_d = S_FETCH; done = 1'b1; end
          C_JAL:   state_d = S_WB;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_ADD, C_SUB, C_ORI, C_LUI: state_d = S_WB;
          C_LW, C_SW:                 state_d = S_MEM;
          default:                    begin state_d = S_FETCH; done = 1'b1; end
        endcase
      end
      S_MEM: begin
        if (dm_ready) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            done    = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        done    = 1'b1;
      end
      // Encodings 5-7 are unreachable in normal operation; recover to FETCH
      // without counting anything.
      default: state_d = S_FETCH;
    endcase
  end

  // State, latched class and retired counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NOP;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= dec_class;
      if (done) retired_q <= retired_q + 32'd1;
    end
  end

  // The class register only loads at the end of DECODE, so DECODE itself shows
  // the selects of the instruction being decoded straight from the IR.
  assign sel_class = (state_q == S_DECODE) ? dec_class : cls_q;

  // Moore-style output decode from state and class, with the im_ready / zero
  // gating on PC_en; reset forces everything to its idle value.
  always_comb begin
    PC_en     = 1'b0;
    IR_en     = 1'b0;
    W_en      = 1'b0;
    DM_we     = 1'b0;
    ALUop     = 3'b000;
    ALUsrc    = 1'b0;
    Wreg_sel  = 2'b00;
    Wdata_sel = 2'b00;
    EXT_sel   = 2'b00;
    Shift_sel = 1'b0;
    NPC_sel   = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          PC_en = im_ready;
          IR_en = im_ready;
        end
        S_DECODE, S_EXEC, S_MEM, S_WB: begin
          case (sel_class)
            C_ADD: begin ALUop = 3'b010; Wreg_sel = 2'b01; end
            C_SUB: begin ALUop = 3'b110; Wreg_sel = 2'b01; end
            C_ORI: begin ALUop = 3'b001; ALUsrc = 1'b1; EXT_sel = 2'b01; end
            C_LUI: begin ALUsrc = 1'b1; Shift_sel = 1'b1; Wdata_sel = 2'b10; end
            C_LW:  begin ALUop = 3'b010; ALUsrc = 1'b1; Wdata_sel = 2'b01; end
            C_SW:  begin ALUop = 3'b010; ALUsrc = 1'b1; end
            C_BEQ: begin ALUop = 3'b110; NPC_sel = 2'b01; end
            C_JAL: begin Wreg_sel = 2'b10; Wdata_sel = 2'b11; NPC_sel = 2'b10; end
            C_JR:  NPC_sel = 2'b11;
            default: ;
          endcase
          if (state_q == S_EXEC && cls_q == C_BEQ) PC_en = zero;
          if (state_q == S_EXEC && cls_q == C_JR)  PC_en = 1'b1;
          if (state_q == S_MEM  && cls_q == C_SW)  DM_we = 1'b1;
          if (state_q == S_WB) begin
            W_en = 1'b1;
            if (cls_q == C_JAL) PC_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: instructions are expanded into per-cycle
// expected outputs from the instruction-level timing rules, queued, and
// compared by an independent monitor on the falling edge.
`timescale 1ns/1ps
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, im_ready, dm_ready;
  logic        PC_en, IR_en, W_en, DM_we, ALUsrc, Shift_sel;
  logic [2:0]  ALUop, state;
  logic [1:0]  Wreg_sel, Wdata_sel, EXT_sel, NPC_sel;
  logic [31:0] retired;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .im_ready(im_ready), .dm_ready(dm_ready), .PC_en(PC_en), .IR_en(IR_en),
    .W_en(W_en), .DM_we(DM_we), .ALUop(ALUop), .ALUsrc(ALUsrc),
    .Wreg_sel(Wreg_sel), .Wdata_sel(Wdata_sel), .EXT_sel(EXT_sel),
    .Shift_sel(Shift_sel), .NPC_sel(NPC_sel), .state(state), .retired(retired)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        pc_en, ir_en, w_en, dm_we;
    logic [2:0]  aluop;
    logic        alusrc;
    logic [1:0]  wreg, wdata, ext;
    logic        shift;
    logic [1:0]  npc;
    logic [31:0] ret;
  } exp_t;

  typedef enum int {K_NOP, K_ADD, K_SUB, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR} kind_t;

  exp_t        exp_q[$];
  exp_t        mon_exp, mon_act;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_retired = '0;

  // Instruction set classification straight from the opcode/funct table.
  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00 && fn == 6'h20) return K_ADD;
    if (op == 6'h00 && fn == 6'h22) return K_SUB;
    if (op == 6'h00 && fn == 6'h08) return K_JR;
    if (op == 6'h0D) return K_ORI;
    if (op == 6'h0F) return K_LUI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h03) return K_JAL;
    return K_NOP;
  endfunction

  // Select values each instruction holds outside FETCH.
  function automatic exp_t class_sel(input kind_t k);
    exp_t e = '0;
    case (k)
      K_ADD: begin e.aluop = 3'b010; e.wreg = 2'b01; end
      K_SUB: begin e.aluop = 3'b110; e.wreg = 2'b01; end
      K_ORI: begin e.aluop = 3'b001; e.alusrc = 1'b1; e.ext = 2'b01; end
      K_LUI: begin e.alusrc = 1'b1; e.shift = 1'b1; e.wdata = 2'b10; end
      K_LW:  begin e.aluop = 3'b010; e.alusrc = 1'b1; e.wdata = 2'b01; end
      K_SW:  begin e.aluop = 3'b010; e.alusrc = 1'b1; end
      K_BEQ: begin e.aluop = 3'b110; e.npc = 2'b01; end
      K_JAL: begin e.wreg = 2'b10; e.wdata = 2'b11; e.npc = 2'b10; end
      K_JR:  e.npc = 2'b11;
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive(input logic r, input logic im, input logic dm, input logic z,
                       input logic [5:0] op, input logic [5:0] fn, input exp_t e);
    @(posedge clk);
    #1;
    reset = r; im_ready = im; dm_ready = dm; zero = z; opcode = op; funct = fn;
    exp_q.push_back(e);
  endtask

  // One instruction: im_w FETCH wait cycles, dm_w MEM wait cycles, zero value
  // seen in EXEC, and the cycle index at which reset is asserted (-1 = none).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int im_w,
                           input int dm_w, input logic zv, input int abort_at);
    kind_t k = classify(op, fn);
    int    ph[$];
    exp_t  e;
    logic  im, dm, z;
    logic [5:0] o, f;
    for (int i = 0; i <= im_w; i++) ph.push_back(0);
    ph.push_back(1);
    case (k)
      K_ADD, K_SUB, K_ORI, K_LUI: begin ph.push_back(2); ph.push_back(4); end
      K_LW: begin
        ph.push_back(2);
        for (int i = 0; i <= dm_w; i++) ph.push_back(3);
        ph.push_back(4);
      end
      K_SW: begin
        ph.push_back(2);
        for (int i = 0; i <= dm_w; i++) ph.push_back(3);
      end
      K_BEQ, K_JR: ph.push_back(2);
      K_JAL:       ph.push_back(4);
      default: ;
    endcase
    for (int c = 0; c < ph.size(); c++) begin
      int st = ph[c];
      e = (st == 0) ? exp_t'('0) : class_sel(k);
      e.st  = 3'(st);
      e.ret = model_retired;
      if (st == 0 && c == im_w) begin e.pc_en = 1'b1; e.ir_en = 1'b1; end
      if (st == 2 && k == K_BEQ) e.pc_en = zv;
      if (st == 2 && k == K_JR)  e.pc_en = 1'b1;
      if (st == 3 && k == K_SW)  e.dm_we = 1'b1;
      if (st == 4) begin
        e.w_en = 1'b1;
        if (k == K_JAL) e.pc_en = 1'b1;
      end
      im = (st == 0) ? (c == im_w) : 1'($urandom_range(0, 1));
      dm = (st == 3) ? (c + 1 >= ph.size() || ph[c + 1] != 3) : 1'($urandom_range(0, 1));
      z  = (st == 2) ? zv : 1'($urandom_range(0, 1));
      o  = (st == 1) ? op : 6'($urandom);
      f  = (st == 1) ? fn : 6'($urandom);
      if (c == abort_at) begin
        e = '0;
        e.st  = 3'(st);
        e.ret = model_retired;
        drive(1'b1, im, dm, z, o, f, e);
        model_retired = '0;
        return;
      end
      drive(1'b0, im, dm, z, o, f, e);
    end
    model_retired = model_retired + 32'd1;
  endtask

  task automatic pick_random(output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case ($urandom_range(0, 11))
      0:  begin op = 6'h00; fn = 6'h20; end
      1:  begin op = 6'h00; fn = 6'h22; end
      2:  op = 6'h0D;
      3:  op = 6'h0F;
      4:  op = 6'h23;
      5:  op = 6'h2B;
      6:  op = 6'h04;
      7:  op = 6'h03;
      8:  begin op = 6'h00; fn = 6'h08; end
      9:  op = 6'($urandom);
      10: op = 6'h00;
      default: op = 6'h3F;
    endcase
  endtask

  // Monitor: one expected vector per clock, compared away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = '{state, PC_en, IR_en, W_en, DM_we, ALUop, ALUsrc, Wreg_sel,
                    Wdata_sel, EXT_sel, Shift_sel, NPC_sel, retired};
        vectors++;
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL cycle_vec %0d at %0t: got st=%0d pc=%b ir=%b w=%b we=%b alu=%b src=%b wr=%b wd=%b ext=%b sh=%b npc=%b ret=%0d, expected st=%0d pc=%b ir=%b w=%b we=%b alu=%b src=%b wr=%b wd=%b ext=%b sh=%b npc=%b ret=%0d",
                   vectors, $time,
                   mon_act.st, mon_act.pc_en, mon_act.ir_en, mon_act.w_en, mon_act.dm_we,
                   mon_act.aluop, mon_act.alusrc, mon_act.wreg, mon_act.wdata, mon_act.ext,
                   mon_act.shift, mon_act.npc, mon_act.ret,
                   mon_exp.st, mon_exp.pc_en, mon_exp.ir_en, mon_exp.w_en, mon_exp.dm_we,
                   mon_exp.aluop, mon_exp.alusrc, mon_exp.wreg, mon_exp.wdata, mon_exp.ext,
                   mon_exp.shift, mon_exp.npc, mon_exp.ret);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Directed sequences.
    run_instr(6'h00, 6'h20, 0, 0, 1'b0, 3);   // add aborted by reset in WB
    run_instr(6'h00, 6'h20, 0, 0, 1'b0, -1);  // add, no waits
    run_instr(6'h00, 6'h22, 0, 0, 1'b1, -1);  // sub
    run_instr(6'h23, 6'h11, 0, 3, 1'b0, -1);  // lw, 3 dm waits
    run_instr(6'h2B, 6'h05, 0, 1, 1'b0, -1);  // sw, 1 dm wait
    run_instr(6'h04, 6'h00, 0, 0, 1'b1, -1);  // beq taken
    run_instr(6'h04, 6'h00, 0, 0, 1'b0, -1);  // beq not taken
    run_instr(6'h03, 6'h00, 0, 0, 1'b0, -1);  // jal
    run_instr(6'h00, 6'h08, 0, 0, 1'b0, -1);  // jr
    run_instr(6'h3F, 6'h3F, 0, 0, 1'b0, -1);  // undefined -> nop
    run_instr(6'h00, 6'h00, 2, 0, 1'b0, -1);  // nop with 2 im waits
    run_instr(6'h0D, 6'h00, 1, 0, 1'b0, -1);  // ori
    run_instr(6'h0F, 6'h00, 0, 0, 1'b0, -1);  // lui
    run_instr(6'h23, 6'h00, 0, 2, 1'b0, 4);   // lw aborted by reset in MEM

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      int ab;
      pick_random(op, fn);
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), ab);
    end

    // Drain: every queued vector must have been consumed within a few cycles.
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control FSM that sequences the shared single-ALU/single-memory datapath for the MIPS subset add, sub, ori, lw, sw, beq, lui, jal, jr, nop. It sits beside the datapath and takes opcode/funct from the instruction register, the ALU zero flag and memory ready handshakes. Each cycle it drives the PC/IR/register-file/data-memory write enables and the datapath mux selects, and it counts retired instructions.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]; valid from DECODE onward
- zero  in  1  ALU result == 0; valid in EXEC
- im_ready  in  1  instruction memory data valid this cycle
- dm_ready  in  1  data memory access completes this cycle
- PC_en  out  1  PC register load
- IR_en  out  1  IR load
- W_en  out  1  register file write
- DM_we  out  1  data memory write
- ALUop  out  3  010 add, 110 sub, 001 or, 000 default
- ALUsrc  out  1  0 rt, 1 extended immediate
- Wreg_sel  out  2  00 rt, 01 rd, 10 $31
- Wdata_sel  out  2  00 ALU, 01 DM, 10 lui shifter, 11 PC+4
- EXT_sel  out  2  01 zero-extend (ori), 00 sign-extend
- Shift_sel  out  1  1 for lui
- NPC_sel  out  2  00 PC+4, 01 beq target, 10 jal target, 11 rs (jr)
- state  out  3  current FSM state (visible for verification)
- retired  out  32  retired-instruction count

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5-7 are illegal; they return to FETCH on the next edge with all enables 0.
- FETCH: waits while im_ready=0 with all enables 0. When im_ready=1: PC_en=1, IR_en=1, NPC_sel=00, then go to DECODE.
- DECODE: latch instruction class from opcode/funct into an internal register. Classes: RTYPE (opcode 0, funct 100000/100010), ORI, LUI, LW, SW, BEQ, JAL, JR (opcode 0, funct 001000), NOP (everything else, including all-zero and undefined encodings). Next state: NOP → FETCH; JAL → WB; all others → EXEC.
- EXEC: ALUop, ALUsrc, EXT_sel and Shift_sel are driven from the latched class.
  - RTYPE, ORI, LUI → WB.
  - LW, SW → MEM; ALUop=010, ALUsrc=1.
  - BEQ: ALUop=110, ALUsrc=0, NPC_sel=01, PC_en=zero → FETCH.
  - JR: PC_en=1, NPC_sel=11 → FETCH.
- MEM: held until dm_ready=1.
  - SW: DM_we=1 every MEM cycle; on dm_ready → FETCH.
  - LW: on dm_ready → WB.
- WB: W_en=1, then → FETCH. Selects by class:
  - RTYPE: Wreg 01, Wdata 00.
  - ORI: Wreg 00, Wdata 00.
  - LUI: Wreg 00, Wdata 10.
  - LW: Wreg 00, Wdata 01.
  - JAL: Wreg 10, Wdata 11, plus PC_en=1 and NPC_sel=10.
- Select outputs hold their class values in every non-FETCH state. Enables are asserted only in the states listed above.
- retired increments by 1 on the final edge of each instruction (the transition back to FETCH out of DECODE/EXEC/MEM/WB) and wraps modulo 2^32.

## Timing
- Outputs are Moore-style: decoded from state and latched class. Exceptions are PC_en in FETCH (gated by im_ready), BEQ PC_en (gated by zero), and MEM exit (gated by dm_ready).
- Cycles per instruction with zero wait states: NOP 2; BEQ, JR, JAL 3; RTYPE, ORI, LUI, SW 4; LW 5. Each im_ready=0 or dm_ready=0 cycle adds 1.
- Reset, any state, takes effect at the edge: state=FETCH, class=NOP, retired=0. While reset=1, all enables are forced to 0 and selects to 00/0.
- Reset asserted mid-instruction aborts it: no W_en or DM_we after the edge, and retired does not count it.
- opcode/funct changes outside DECODE have no effect.

## Test plan
- Reset in WB of an add, then release → state=0, retired=0, W_en=0 during reset; next instruction proceeds normally.
- add $3,$1,$2 with no waits → states 0,1,2,4; W_en=1 only in WB with Wreg_sel=01, ALUop=010 in EXEC; retired increments by 1 after 4 cycles.
- lw with dm_ready low for 3 cycles → MEM held 4 cycles, W_en=1 with Wdata_sel=01 in the following cycle, total 8 cycles; sw with one wait → DM_we=1 for 2 cycles, 5 cycles total.
- beq with zero=1, then with zero=0 → EXEC PC_en=1 with NPC_sel=01, then PC_en=0; both take 3 cycles and both increment retired.
- jal → WB PC_en=1, NPC_sel=10, Wreg_sel=10, Wdata_sel=11, 3 cycles; jr → EXEC PC_en=1, NPC_sel=11, W_en never asserted.
- opcode 0x3F → treated as NOP (2 cycles, no enables after FETCH); im_ready=0 for 2 cycles → FETCH held with PC_en=IR_en=0.
